qtr_sense: RTL and testbench



---
 rtl/qtr_sense.sv | 69 ++++++
 tb/tb_qtr_sense.sv | 110 +++++++++++
 2 files changed

// File: rtl/qtr_sense.sv
// qtr_sense: QTR RC reflectance sensor timer (charge, release, time discharge in ticks).
module qtr_sense #(
    parameter int CLK_FREQUENCY = 60_000_000,
    parameter int CHARGE_US = 10,
    parameter int TICK_US = 10
) (
    input  logic       hba_clk,
    input  logic       hba_reset,
    input  logic       en,
    output logic [7:0] value,
    output logic       valid,
    output logic       qtr_out_en,
    output logic       qtr_out_sig,
    input  logic       qtr_in_sig,
    output logic       qtr_ctrl
);
    localparam int CHARGE_CYCLES = CLK_FREQUENCY / 1_000_000 * CHARGE_US;
    localparam int TICK_CYCLES = CLK_FREQUENCY / 1_000_000 * TICK_US;
    localparam int CW = $clog2(CHARGE_CYCLES + 1);
    localparam int TW = $clog2(TICK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, DONE} state_t;

    state_t state, state_nx;
    logic s1, in_s;
    logic [CW-1:0] cyc;
    logic [TW-1:0] tick;
    logic [7:0] cnt;
    logic charge_end, wrap;

    assign charge_end = cyc == CW'(CHARGE_CYCLES - 1);
    assign wrap = tick == TW'(TICK_CYCLES - 1);
    assign qtr_out_en = state == CHARGE;
    assign qtr_out_sig = state == CHARGE;
    assign qtr_ctrl = state == CHARGE || state == MEASURE;
    assign valid = state == DONE;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = en ? CHARGE : IDLE;
            CHARGE:  state_nx = charge_end ? MEASURE : CHARGE;
            MEASURE: state_nx = (!in_s || (wrap && cnt == 8'hff)) ? DONE : MEASURE;
            default: state_nx = IDLE;
        endcase
    end

    // Synchronizer idles high so a fresh reset never looks like an early discharge.
    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state <= IDLE;
            s1 <= 1'b1;
            in_s <= 1'b1;
            cyc <= '0;
            tick <= '0;
            cnt <= '0;
            value <= '0;
        end else begin
            state <= state_nx;
            s1 <= qtr_in_sig;
            in_s <= s1;
            cyc <= state == CHARGE ? cyc + CW'(1) : '0;
            tick <= (state == MEASURE && !wrap) ? tick + TW'(1) : '0;
            cnt <= state == MEASURE ? cnt + 8'(wrap && cnt != 8'hff) : '0;
            if (state == MEASURE && state_nx == DONE)
                value <= in_s ? 8'hff : cnt;
        end
    end
endmodule

// File: tb/tb_qtr_sense.sv
// tb_qtr_sense: randomized discharge-time checks against a closed-form timing model.
module tb_qtr_sense;
    logic hba_clk = 1'b0;
    logic hba_reset = 1'b1;
    logic en = 1'b0;
    logic qtr_in_sig = 1'b1;
    logic [7:0] value;
    logic valid, qtr_out_en, qtr_out_sig, qtr_ctrl;
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] prev = 8'h00;

    qtr_sense #(.CLK_FREQUENCY(1_000_000), .CHARGE_US(10), .TICK_US(10)) dut (
        .hba_clk(hba_clk),
        .hba_reset(hba_reset),
        .en(en),
        .value(value),
        .valid(valid),
        .qtr_out_en(qtr_out_en),
        .qtr_out_sig(qtr_out_sig),
        .qtr_in_sig(qtr_in_sig),
        .qtr_ctrl(qtr_ctrl)
    );

    always #5 hba_clk = ~hba_clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {valid, qtr_out_en, qtr_out_sig, qtr_ctrl, value};
    endfunction

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge hba_clk);
            chk("idle", 32'(obs()), 32'({4'b0000, prev}));
            en = 1'b0;
            qtr_in_sig = 1'b1;
        end
    endtask

    // en is raised in period -1; CHARGE spans periods 0..9, MEASURE starts at 10.
    // The pin drops in period 10+d, seen two periods later through the synchronizer.
    task automatic run_meas(int d, bit busy);
        int k, done;
        logic [7:0] v;
        logic [3:0] e;
        k = (d + 2 < 0) ? 0 : d + 2;
        done = 10 + ((k < 2560) ? k + 1 : 2560);
        v = (k < 2560) ? 8'(k / 10) : 8'hff;
        for (int p = -1; p <= done; p++) begin
            @(negedge hba_clk);
            e = p < 0 ? 4'b0000 : p < 10 ? 4'b0111 : p < done ? 4'b0001 : 4'b1000;
            chk($sformatf("meas d=%0d p=%0d", d, p), 32'(obs()), 32'({e, (p == done) ? v : prev}));
            en = (p < 0) || (busy && $urandom_range(0, 5) == 0);
            qtr_in_sig = (p >= 10 + d) ? 1'b0 : 1'b1;
        end
        prev = v;
    endtask

    initial begin
        #1;
        chk("reset_state", 32'(obs()), 32'(0));
        repeat (3) @(negedge hba_clk);
        hba_reset = 1'b0;
        idle(2);
        run_meas(42, 1'b0);
        idle(1);
        run_meas(3000, 1'b0);
        idle(2);
        run_meas(-10, 1'b0);
        idle(1);
        run_meas(42, 1'b1);
        run_meas(8, 1'b0);
        run_meas(2556, 1'b0);
        run_meas(2557, 1'b0);
        run_meas(0, 1'b1);
        idle(2);
        @(negedge hba_clk);
        en = 1'b1;
        for (int p = 0; p < 5; p++) begin
            @(negedge hba_clk);
            en = 1'b0;
        end
        @(negedge hba_clk);
        chk("charge_before_reset", 32'(obs()), 32'({4'b0111, prev}));
        hba_reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(obs()), 32'(0));
        @(negedge hba_clk);
        chk("held_reset", 32'(obs()), 32'(0));
        hba_reset = 1'b0;
        prev = 8'h00;
        idle(2);
        run_meas(42, 1'b0);
        repeat (12) begin
            run_meas(int'($urandom_range(0, 2610)) - 10, 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
